fp_vec_mul: RTL and testbench

FP_VEC_MUL -- requirements
Module: fp_vec_mul

---
 rtl/fp_vec_mul_if.sv | 25 ++
 rtl/fp_vec_mul.sv | 167 ++++++++++++++++
 tb/tb_fp_vec_mul.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_vec_mul_if.sv
// fp_vec_mul_if: lane-vector bus for the pipelined FP multiplier.
//   enable    - pipeline advance (low freezes every stage)
//   in_valid  - qualifies idataA/idataB on an enabled cycle
//   idataA/B  - packed operands, lane k at [k*I_DATA +: I_DATA]
//   odata     - packed products, same packing
//   out_valid - odata holds a valid result vector
//   oflags    - per-lane {inv, ovf, unf}, lane k at [k*3 +: 3]
// master = producer/consumer side, slave = the multiplier.
interface fp_vec_mul_if #(
  parameter int I_DATA = 32,
  parameter int LANES  = 4
);
  logic                      enable;
  logic                      in_valid;
  logic [LANES*I_DATA-1:0]   idataA;
  logic [LANES*I_DATA-1:0]   idataB;
  logic [LANES*I_DATA-1:0]   odata;
  logic                      out_valid;
  logic [LANES*3-1:0]        oflags;

  modport master (output enable, in_valid, idataA, idataB,
                  input  odata, out_valid, oflags);
  modport slave  (input  enable, in_valid, idataA, idataB,
                  output odata, out_valid, oflags);
endinterface

// File: rtl/fp_vec_mul.sv
// fp_vec_mul: LANES independent IEEE-style FP multipliers, 3-stage pipeline
// (S1 unpack/classify, S2 significand product, S3 normalise/round/pack).
// Flush-to-zero on inputs, no subnormal outputs, round-to-nearest-even.
// Ports: clk, reset (sync, active high), bus (fp_vec_mul_if.slave).

// One multiplier lane; stage registers freeze while enable is low.
//   a, b  - operands {sign, exp, mnt}
//   res   - registered product
//   flags - registered {inv, ovf, unf}
module fp_mul_lane #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [I_DATA-1:0] a,
  input  logic [I_DATA-1:0] b,
  output logic [I_DATA-1:0] res,
  output logic [2:0]        flags
);
  localparam int EW = I_EXP + 2;       // signed exponent width
  localparam int PW = 2 * I_MNT + 2;   // significand product width
  localparam logic [EW-1:0]        BIAS    = EW'((1 << (I_EXP - 1)) - 1);
  localparam logic [I_EXP-1:0]     EMAX    = '1;
  localparam logic signed [EW-1:0] EXP_INF = EW'((1 << I_EXP) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  // ---- S1: unpack and classify
  logic             sa, sb;
  logic [I_EXP-1:0] ea, eb;
  logic [I_MNT-1:0] ma, mb;
  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, c_inv, c_inf, c_zero;
  always_comb begin
    a_nan  = (ea == EMAX) && (ma != '0);
    b_nan  = (eb == EMAX) && (mb != '0);
    a_inf  = (ea == EMAX) && (ma == '0);
    b_inf  = (eb == EMAX) && (mb == '0);
    a_zero = (ea == '0);               // subnormals flush to zero
    b_zero = (eb == '0);
    c_inv  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    c_inf  = (a_inf | b_inf) & ~c_inv;
    c_zero = (a_zero | b_zero) & ~c_inv & ~c_inf;
  end

  logic           s1_sign;
  logic [EW-1:0]  s1_exp;
  logic [I_MNT:0] s1_ma, s1_mb;
  logic [2:0]     s1_cls;              // {inv, inf, zero}
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sign <= 1'b0; s1_exp <= '0; s1_ma <= '0; s1_mb <= '0; s1_cls <= '0;
    end else if (enable) begin
      s1_sign <= sa ^ sb;
      s1_exp  <= {2'b00, ea} + {2'b00, eb} - BIAS;
      s1_ma   <= {1'b1, ma};
      s1_mb   <= {1'b1, mb};
      s1_cls  <= {c_inv, c_inf, c_zero};
    end
  end

  // ---- S2: significand product
  logic          s2_sign;
  logic [EW-1:0] s2_exp;
  logic [PW-1:0] s2_prod;
  logic [2:0]    s2_cls;
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sign <= 1'b0; s2_exp <= '0; s2_prod <= '0; s2_cls <= '0;
    end else if (enable) begin
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_cls  <= s1_cls;
    end
  end

  // ---- S3: normalise, round, pack
  // Product of two [1,2) significands lies in [1,4): either the top bit is
  // set (shift right / exp+1) or the next bit is; left-align so the hidden
  // bit is dropped and mantissa/guard/sticky sit at fixed positions.
  logic [PW-2:0]       nrm;
  logic [I_MNT-1:0]    mnt, mnt_r;
  logic                guard, sticky, rnd, carry;
  logic signed [EW-1:0] exp_r;
  logic [I_DATA-1:0]   nxt_res;
  logic [2:0]          nxt_flags;
  always_comb begin
    nrm    = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    mnt    = nrm[PW-2 -: I_MNT];
    guard  = nrm[PW-2-I_MNT];
    sticky = |nrm[PW-3-I_MNT:0];
    rnd    = guard & (sticky | mnt[0]);
    {carry, mnt_r} = {1'b0, mnt} + {{I_MNT{1'b0}}, rnd};
    // carry means mnt wrapped to zero, i.e. significand became 2.0
    exp_r  = s2_exp + EW'(s2_prod[PW-1]) + EW'(carry);

    nxt_res   = {1'b0, EMAX, 1'b1, {(I_MNT-1){1'b0}}};
    nxt_flags = 3'b100;
    if (s2_cls[2]) begin
      nxt_res   = {1'b0, EMAX, 1'b1, {(I_MNT-1){1'b0}}};
      nxt_flags = 3'b100;
    end else if (s2_cls[1]) begin
      nxt_res   = {s2_sign, EMAX, {I_MNT{1'b0}}};
      nxt_flags = 3'b000;
    end else if (s2_cls[0]) begin
      nxt_res   = {s2_sign, {(I_DATA-1){1'b0}}};
      nxt_flags = 3'b000;
    end else if (exp_r >= EXP_INF) begin
      nxt_res   = {s2_sign, EMAX, {I_MNT{1'b0}}};
      nxt_flags = 3'b010;
    end else if (exp_r < EXP_ONE) begin
      nxt_res   = {s2_sign, {(I_DATA-1){1'b0}}};
      nxt_flags = 3'b001;
    end else begin
      nxt_res   = {s2_sign, exp_r[I_EXP-1:0], mnt_r};
      nxt_flags = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res   <= '0;
      flags <= '0;
    end else if (enable) begin
      res   <= nxt_res;
      flags <= nxt_flags;
    end
  end
endmodule

module fp_vec_mul #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1,
  parameter int LANES  = 4
) (
  input  logic         clk,
  input  logic         reset,
  fp_vec_mul_if.slave  bus
);
  localparam int STAGES = 3;

  // valid travels alongside the lane data, one bit per stage
  logic [STAGES:1] vld_pipe;
  always_ff @(posedge clk) begin
    if (reset)           vld_pipe <= '0;
    else if (bus.enable) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end
  assign bus.out_valid = vld_pipe[STAGES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp_mul_lane #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (bus.enable),
      .a      (bus.idataA[k*I_DATA +: I_DATA]),
      .b      (bus.idataB[k*I_DATA +: I_DATA]),
      .res    (bus.odata[k*I_DATA +: I_DATA]),
      .flags  (bus.oflags[k*3 +: 3])
    );
  end
endmodule

// File: tb/tb_fp_vec_mul.sv
// tb_fp_vec_mul: scoreboard bench for fp_vec_mul (binary32, 4 lanes).
// Stimulus pushes expected vectors (table constants or a numeric model);
// a negedge monitor pops/compares on each advanced valid output, checks
// latency in enabled cycles, freeze during stalls and reset clearing.
module tb_fp_vec_mul;
  logic clk;
  logic reset;
  fp_vec_mul_if #(.I_DATA(32), .LANES(4)) bus ();

  fp_vec_mul #(.I_EXP(8), .I_MNT(23), .I_DATA(32), .LANES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [11:0]  f;
    int           t;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int ecnt = 0;          // enabled, non-reset clock edges seen
  bit adv = 0, rst_seen = 0, armed = 0;
  logic         last_v;
  logic [127:0] last_d;
  logic [11:0]  last_f;

  logic [31:0] dA[12], dB[12], dR[12];
  logic [2:0]  dF[12];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded
  // remainder against one half ulp.
  task automatic fmul(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output logic [2:0] f);
    logic s;
    int ea, eb, e, sh;
    bit an, bn, ai, bi, az, bz;
    longint unsigned pa, pb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    f  = 3'b000;
    if (an || bn || (ai && bz) || (az && bi)) begin
      r = 32'h7FC00000; f = 3'b100;
    end else if (ai || bi) begin
      r = {s, 8'hFF, 23'd0};
    end else if (az || bz) begin
      r = {s, 31'd0};
    end else begin
      pa = 64'(a[22:0]) + (64'd1 << 23);
      pb = 64'(b[22:0]) + (64'd1 << 23);
      p  = pa * pb;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = ea + eb - 127 + (sh - 23);
      q  = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
      if (e >= 255)    begin r = {s, 8'hFF, 23'd0}; f = 3'b010; end
      else if (e <= 0) begin r = {s, 31'd0};        f = 3'b001; end
      else r = {s, 8'(e), q[22:0]};
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: r[30:23] = 8'd0;
      1: begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) r[22:0] = '0; end
      2: r[30:23] = 8'($urandom_range(190, 254));
      3: r[30:23] = 8'($urandom_range(1, 64));
      4: begin r[30:23] = 8'($urandom_range(110, 140)); r[10:0] = '0; end
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  // dl = lane carrying directed entry di (-1: all lanes random)
  task automatic build(input int dl, input int di,
                       output logic [127:0] A, output logic [127:0] B,
                       output logic [127:0] xd, output logic [11:0] xf);
    logic [31:0] a, b, r;
    logic [2:0]  f;
    for (int k = 0; k < 4; k++) begin
      if (k == dl) begin
        a = dA[di]; b = dB[di]; r = dR[di]; f = dF[di];
      end else begin
        a = rand_fp(); b = rand_fp(); fmul(a, b, r, f);
      end
      A[k*32 +: 32] = a; B[k*32 +: 32] = b;
      xd[k*32 +: 32] = r; xf[k*3 +: 3] = f;
    end
  endtask

  task automatic issue(input int dl, input int di);
    logic [127:0] A, B, xd;
    logic [11:0]  xf;
    exp_t e;
    build(dl, di, A, B, xd, xf);
    bus.enable = 1'b1; bus.in_valid = 1'b1;
    bus.idataA = A;    bus.idataB = B;
    e.d = xd; e.f = xf; e.t = ecnt;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input bit en);
    bus.enable = en; bus.in_valid = 1'b0;
    bus.idataA = {$urandom, $urandom, $urandom, $urandom};
    bus.idataB = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    bus.enable = 1'b1;
  endtask

  // stalled cycle with live-looking inputs that must be ignored
  task automatic stall();
    bus.enable = 1'b0; bus.in_valid = 1'b1;
    bus.idataA = {$urandom, $urandom, $urandom, $urandom};
    bus.idataB = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    bus.enable = 1'b1; bus.in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    adv      <= bus.enable && !reset;
    rst_seen <= reset;
    if (reset) armed <= 1'b1;
    if (bus.enable && !reset) ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (rst_seen) begin
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_odata", bus.odata, 128'(0));
        chk("rst_oflags", 128'(bus.oflags), 128'(0));
      end else if (adv) begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got %h, expected no output", bus.odata);
          end else begin
            e = sb.pop_front();
            chk("odata", bus.odata, e.d);
            chk("oflags", 128'(bus.oflags), 128'(e.f));
            chk("latency", 128'(ecnt - e.t), 128'(3));
          end
        end
      end else begin
        chk("stall_out_valid", 128'(bus.out_valid), 128'(last_v));
        chk("stall_odata", bus.odata, last_d);
        chk("stall_oflags", 128'(bus.oflags), 128'(last_f));
      end
    end
    last_v = bus.out_valid;
    last_d = bus.odata;
    last_f = bus.oflags;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dA[0]  = 32'h3FC00000; dB[0]  = 32'h40000000; dR[0]  = 32'h40400000; dF[0]  = 3'b000;
    dA[1]  = 32'hC0400000; dB[1]  = 32'h40000000; dR[1]  = 32'hC0C00000; dF[1]  = 3'b000;
    dA[2]  = 32'h3F800800; dB[2]  = 32'h3F800800; dR[2]  = 32'h3F801000; dF[2]  = 3'b000;
    dA[3]  = 32'h3F800001; dB[3]  = 32'h3F800001; dR[3]  = 32'h3F800002; dF[3]  = 3'b000;
    dA[4]  = 32'h7F800000; dB[4]  = 32'h00000000; dR[4]  = 32'h7FC00000; dF[4]  = 3'b100;
    dA[5]  = 32'h7F000000; dB[5]  = 32'h40000000; dR[5]  = 32'h7F800000; dF[5]  = 3'b010;
    dA[6]  = 32'h00800000; dB[6]  = 32'h3F000000; dR[6]  = 32'h00000000; dF[6]  = 3'b001;
    dA[7]  = 32'h7F800001; dB[7]  = 32'h3F800000; dR[7]  = 32'h7FC00000; dF[7]  = 3'b100;
    dA[8]  = 32'hFF800000; dB[8]  = 32'h40000000; dR[8]  = 32'hFF800000; dF[8]  = 3'b000;
    dA[9]  = 32'h80000000; dB[9]  = 32'h40A00000; dR[9]  = 32'h80000000; dF[9]  = 3'b000;
    dA[10] = 32'h00400000; dB[10] = 32'hC0000000; dR[10] = 32'h80000000; dF[10] = 3'b000;
    dA[11] = 32'h3F800000; dB[11] = 32'hBF800000; dR[11] = 32'hBF800000; dF[11] = 3'b000;

    reset = 1'b1; bus.enable = 1'b0; bus.in_valid = 1'b0;
    bus.idataA = '0; bus.idataB = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1'b1);

    // directed cases, rotating through the lanes
    for (int i = 0; i < 12; i++) issue(i % 4, i);
    repeat (5) idle(1'b1);

    // 10 back-to-back vectors, 2-cycle stall before vector 4
    for (int v = 0; v < 10; v++) begin
      if (v == 4) begin stall(); stall(); end
      issue(-1, 0);
    end
    repeat (5) idle(1'b1);

    // random mix of valids, bubbles and stalls
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       idle(1'b1);
        1:       stall();
        default: issue(-1, 0);
      endcase
    end
    repeat (5) idle(1'b1);

    // reset with 2 vectors in flight: they must never emerge
    issue(-1, 0);
    issue(-1, 0);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) idle(1'b1);
    issue(0, 0);
    issue(-1, 0);
    repeat (6) idle(1'b1);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
